mix_scheduler: RTL and testbench

//  Per-sample sequencer feeding the looper mixer. On each sample_tick it walks banks 0..NUM_CH-1,

---
 rtl/mix_scheduler.sv | 252 +++++++++++++++++++++++++
 tb/tb_mix_scheduler.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_scheduler.sv
// -----------------------------------------------------------------------------
// mix_scheduler
//   Per-sample sequencer between the DDR read port and the looper mixer.
//   On each accepted sample_tick it walks banks 0..NUM_CH-1. A playing bank
//   gets one 64-bit read at {bank, position}; an idle bank presents word 0.
//   Each word is shown for one data_ready cycle and then held for one more
//   cycle so the mixer can sample it. After the last bank, mix_data pulses
//   and the shared loop position advances.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   sample_tick     1-cycle frame pulse (dropped and flagged if busy)
//   playing         per-bank play enables, latched at frame start
//   loop_len        loop length in samples (0 holds position at 0)
//   pos_clr         clear position now (IDLE) or at the next MIX
//   rd_req/rd_addr  memory read request, address {bank, position}
//   rd_ack          request accepted
//   rd_valid/rd_data read data return
//   data_ready      word presented to the mixer this cycle
//   mem_bank        bank of the presented word
//   mem_dq_o_b      presented word
//   mix_data        1-cycle "sum now" pulse
//   position        current loop position
//   busy            frame in progress
//   overrun         sticky, tick arrived while busy
//   timeout_err     sticky, a bank read was abandoned
//   err_clr         clears overrun and timeout_err
// -----------------------------------------------------------------------------
module mix_scheduler #(
    parameter int unsigned NUM_CH  = 16,
    parameter int unsigned POS_W   = 24,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sample_tick,
    input  logic [15:0]          playing,
    input  logic [POS_W-1:0]     loop_len,
    input  logic                 pos_clr,
    output logic                 rd_req,
    output logic [4+POS_W-1:0]   rd_addr,
    input  logic                 rd_ack,
    input  logic                 rd_valid,
    input  logic [63:0]          rd_data,
    output logic                 data_ready,
    output logic [3:0]           mem_bank,
    output logic [63:0]          mem_dq_o_b,
    output logic                 mix_data,
    output logic [POS_W-1:0]     position,
    output logic                 busy,
    output logic                 overrun,
    output logic                 timeout_err,
    input  logic                 err_clr
);

    localparam int unsigned BANK_W = 4;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SCAN,
        S_REQ,
        S_WAIT_DATA,
        S_PRESENT,
        S_HOLD,
        S_MIX
    } state_t;

    state_t              state_q, state_d;
    logic [BANK_W-1:0]   bank_q, bank_d;
    logic [TO_W-1:0]     tcnt_q, tcnt_d;
    logic [15:0]         playing_q, playing_d;
    logic                clr_pend_q, clr_pend_d;

    logic [POS_W-1:0]    pos_d;
    logic [BANK_W-1:0]   mbank_d;
    logic [DATA_W-1:0]   dq_d;
    logic                ovr_d;
    logic                terr_d;
    logic                to_set;
    logic                tmo_hit;
    logic                rd_req_d;
    logic                data_ready_d;
    logic                mix_data_d;
    logic                busy_d;

    // Address is built from registered bank and position, both stable in REQ.
    assign rd_addr = {bank_q, position};

    // Read budget exhausted on the last allowed REQ/WAIT_DATA cycle.
    assign tmo_hit = (tcnt_q == TO_W'(TIMEOUT - 1));

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bank_q      <= '0;
            tcnt_q      <= '0;
            playing_q   <= '0;
            clr_pend_q  <= 1'b0;
            rd_req      <= 1'b0;
            data_ready  <= 1'b0;
            mix_data    <= 1'b0;
            busy        <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
            mem_bank    <= '0;
            mem_dq_o_b  <= '0;
            position    <= '0;
        end else begin
            state_q     <= state_d;
            bank_q      <= bank_d;
            tcnt_q      <= tcnt_d;
            playing_q   <= playing_d;
            clr_pend_q  <= clr_pend_d;
            rd_req      <= rd_req_d;
            data_ready  <= data_ready_d;
            mix_data    <= mix_data_d;
            busy        <= busy_d;
            overrun     <= ovr_d;
            timeout_err <= terr_d;
            mem_bank    <= mbank_d;
            mem_dq_o_b  <= dq_d;
            position    <= pos_d;
        end
    end

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d    = state_q;
        bank_d     = bank_q;
        tcnt_d     = tcnt_q;
        playing_d  = playing_q;
        clr_pend_d = clr_pend_q;
        pos_d      = position;
        mbank_d    = mem_bank;
        dq_d       = mem_dq_o_b;
        ovr_d      = overrun;
        terr_d     = timeout_err;
        to_set     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pos_clr) begin
                    pos_d = '0;
                end
                if (sample_tick) begin
                    playing_d = playing;
                    bank_d    = '0;
                    state_d   = S_SCAN;
                end
            end

            S_SCAN: begin
                if (playing_q[bank_q]) begin
                    tcnt_d  = '0;
                    state_d = S_REQ;
                end else begin
                    mbank_d = bank_q;
                    dq_d    = '0;
                    state_d = S_PRESENT;
                end
            end

            // Timeout wins over a same-cycle ack: the budget is already spent.
            S_REQ: begin
                if (tmo_hit) begin
                    mbank_d = bank_q;
                    dq_d    = '0;
                    to_set  = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                    if (rd_ack) begin
                        state_d = S_WAIT_DATA;
                    end
                end
            end

            // Data arriving on the last allowed cycle is still accepted.
            S_WAIT_DATA: begin
                if (rd_valid) begin
                    mbank_d = bank_q;
                    dq_d    = rd_data;
                    state_d = S_PRESENT;
                end else if (tmo_hit) begin
                    mbank_d = bank_q;
                    dq_d    = '0;
                    to_set  = 1'b1;
                    state_d = S_PRESENT;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end

            S_PRESENT: begin
                state_d = S_HOLD;
            end

            S_HOLD: begin
                if (bank_q == BANK_W'(NUM_CH - 1)) begin
                    state_d = S_MIX;
                end else begin
                    bank_d  = bank_q + BANK_W'(1);
                    state_d = S_SCAN;
                end
            end

            // Wrap compare is unsigned over the full width; loop_len==0 guards the subtract.
            S_MIX: begin
                if (pos_clr || clr_pend_q || (loop_len == '0) ||
                    (position >= loop_len - POS_W'(1))) begin
                    pos_d = '0;
                end else begin
                    pos_d = position + POS_W'(1);
                end
                clr_pend_d = 1'b0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A clear requested mid-frame is remembered until the frame's MIX.
        if (pos_clr && (state_q != S_IDLE) && (state_q != S_MIX)) begin
            clr_pend_d = 1'b1;
        end

        // Sticky flags; err_clr beats any same-cycle set.
        if (err_clr) begin
            ovr_d  = 1'b0;
            terr_d = 1'b0;
        end else begin
            if (sample_tick && (state_q != S_IDLE)) begin
                ovr_d = 1'b1;
            end
            if (to_set) begin
                terr_d = 1'b1;
            end
        end

        // Moore outputs registered from the next state.
        rd_req_d     = (state_d == S_REQ);
        data_ready_d = (state_d == S_PRESENT);
        mix_data_d   = (state_d == S_MIX);
        busy_d       = (state_d != S_IDLE);
    end

endmodule

// File: tb/tb_mix_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mix_scheduler
//   Directed bench for mix_scheduler. A frame-level model computes, at each
//   accepted tick, the cycle at which every bank is requested and presented
//   and when the mix pulse lands, from per-bank cycle costs. A compare process
//   checks every output against it on every cycle; literal checks pin the
//   model for the directed scenarios.
// -----------------------------------------------------------------------------
module tb_mix_scheduler;

    localparam int unsigned NUM_CH  = 16;
    localparam int unsigned POS_W   = 24;
    localparam int unsigned TIMEOUT = 255;

    logic                clk = 1'b0;
    logic                rst;
    logic                sample_tick;
    logic [15:0]         playing;
    logic [POS_W-1:0]    loop_len;
    logic                pos_clr;
    logic                rd_req;
    logic [4+POS_W-1:0]  rd_addr;
    logic                rd_ack   = 1'b0;
    logic                rd_valid = 1'b0;
    logic [63:0]         rd_data  = 64'h0;
    logic                data_ready;
    logic [3:0]          mem_bank;
    logic [63:0]         mem_dq_o_b;
    logic                mix_data;
    logic [POS_W-1:0]    position;
    logic                busy;
    logic                overrun;
    logic                timeout_err;
    logic                err_clr;

    mix_scheduler #(.NUM_CH(NUM_CH), .POS_W(POS_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .sample_tick(sample_tick), .playing(playing),
        .loop_len(loop_len), .pos_clr(pos_clr), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_ack(rd_ack), .rd_valid(rd_valid), .rd_data(rd_data),
        .data_ready(data_ready), .mem_bank(mem_bank), .mem_dq_o_b(mem_dq_o_b),
        .mix_data(mix_data), .position(position), .busy(busy), .overrun(overrun),
        .timeout_err(timeout_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Memory responder configuration.
    int ack_lat     = 0;
    int val_lat     = 0;
    bit never_valid = 1'b0;

    // Memory responder: ack after ack_lat extra REQ cycles, valid after val_lat extra wait cycles.
    int               rc = 0;
    int               wc = 0;
    bit               waiting = 1'b0;
    logic [27:0]      addr_l = 28'h0;
    always @(negedge clk) begin
        rd_ack   = 1'b0;
        rd_valid = 1'b0;
        if (rd_req === 1'b1) begin
            rc++;
            wc      = 0;
            waiting = 1'b0;
            if (rc == ack_lat + 1) begin
                rd_ack  = 1'b1;
                rc      = 0;
                waiting = 1'b1;
                addr_l  = rd_addr;
            end
        end else begin
            rc = 0;
            if (waiting) begin
                wc++;
                if (wc == val_lat + 1) begin
                    waiting = 1'b0;
                    if (!never_valid) begin
                        rd_valid = 1'b1;
                        rd_data  = {36'hA5A5A5A5A, addr_l};
                    end
                end
            end
        end
    end

    // Frame-level model.
    int               cyc = 0;
    bit               active = 1'b0;
    int               t_start = 0;
    int               frame_end = 0;
    int               pres[16];
    int               rlo[16];
    int               rhi[16];
    bit               tob[16];
    logic [63:0]      wrd[16];
    logic [POS_W-1:0] m_pos = '0;
    logic [3:0]       m_bank = 4'h0;
    logic [63:0]      m_dq = 64'h0;
    bit               m_ovr = 1'b0;
    bit               m_to = 1'b0;

    always @(posedge clk) begin
        int prev;
        bit busy_prev;
        bit to_evt;
        int s;
        int len;
        prev      = cyc;
        cyc       = cyc + 1;
        busy_prev = active && (prev >= t_start) && (prev <= frame_end);
        to_evt    = 1'b0;
        if (rst) begin
            active = 1'b0;
            m_pos  = '0;
            m_bank = 4'h0;
            m_dq   = 64'h0;
            m_ovr  = 1'b0;
            m_to   = 1'b0;
        end else begin
            if (active) begin
                for (int b = 0; b < 16; b++) begin
                    if (cyc == pres[b]) begin
                        m_bank = 4'(b);
                        m_dq   = wrd[b];
                        if (tob[b]) to_evt = 1'b1;
                    end
                end
            end
            if (err_clr) begin
                m_ovr = 1'b0;
                m_to  = 1'b0;
            end else begin
                if (sample_tick && busy_prev) m_ovr = 1'b1;
                if (to_evt) m_to = 1'b1;
            end
            if (active && (cyc == frame_end + 1)) begin
                if (pos_clr || loop_len == 0 || int'(m_pos) + 1 >= int'(loop_len))
                    m_pos = '0;
                else
                    m_pos = m_pos + 1'b1;
                active = 1'b0;
            end
            if (!busy_prev && pos_clr) m_pos = '0;
            if (!busy_prev && sample_tick) begin
                t_start = cyc;
                s       = cyc;
                for (int b = 0; b < 16; b++) begin
                    if (playing[b]) begin
                        len    = never_valid ? int'(TIMEOUT) : ack_lat + val_lat + 2;
                        rlo[b] = s + 1;
                        rhi[b] = s + 1 + ack_lat;
                        pres[b] = s + 1 + len;
                        tob[b] = never_valid;
                        wrd[b] = never_valid ? 64'h0 : {36'hA5A5A5A5A, 4'(b), m_pos};
                    end else begin
                        len    = 0;
                        rlo[b] = s + 1;
                        rhi[b] = s;
                        pres[b] = s + 1;
                        tob[b] = 1'b0;
                        wrd[b] = 64'h0;
                    end
                    s = s + 3 + len;
                end
                frame_end = s;
                active    = 1'b1;
            end
        end
    end

    // Per-cycle compare plus event bookkeeping for the literal checks.
    bit          chk_en = 1'b0;
    int          mix_cnt = 0;
    int          mix_lat = 0;
    int          dr_cnt = 0;
    int          req_cnt = 0;
    logic [63:0] seen_word[16];

    always @(negedge clk) begin
        bit          inf;
        bit          e_dr;
        bit          e_req;
        logic [27:0] e_addr;
        if (chk_en) begin
            inf    = active && (cyc >= t_start) && (cyc <= frame_end);
            e_dr   = 1'b0;
            e_req  = 1'b0;
            e_addr = 28'h0;
            if (inf) begin
                for (int b = 0; b < 16; b++) begin
                    if (cyc == pres[b]) e_dr = 1'b1;
                    if (cyc >= rlo[b] && cyc <= rhi[b]) begin
                        e_req  = 1'b1;
                        e_addr = {4'(b), m_pos};
                    end
                end
            end
            chk("busy",        64'(busy),        64'(inf));
            chk("mix_data",    64'(mix_data),    64'(inf && cyc == frame_end));
            chk("data_ready",  64'(data_ready),  64'(e_dr));
            chk("rd_req",      64'(rd_req),      64'(e_req));
            if (e_req) chk("rd_addr", 64'(rd_addr), 64'(e_addr));
            chk("mem_bank",    64'(mem_bank),    64'(m_bank));
            chk("mem_dq_o_b",  mem_dq_o_b,       m_dq);
            chk("position",    64'(position),    64'(m_pos));
            chk("overrun",     64'(overrun),     64'(m_ovr));
            chk("timeout_err", 64'(timeout_err), 64'(m_to));

            if (inf && cyc == t_start) begin
                for (int b = 0; b < 16; b++) seen_word[b] = 64'hFFFF_FFFF_FFFF_FFFF;
            end
            if (data_ready === 1'b1) begin
                dr_cnt++;
                seen_word[mem_bank] = mem_dq_o_b;
            end
            if (rd_req === 1'b1) req_cnt++;
            if (mix_data === 1'b1) begin
                mix_cnt++;
                mix_lat = cyc - t_start + 1;
            end
        end
    end

    task automatic wait_mix(input int m0, output int lat);
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (mix_cnt != m0) break;
        end
        chk("mix_seen", 64'(mix_cnt != m0), 64'd1);
        lat = mix_lat;
        @(negedge clk);
    endtask

    // Tick with playing=pl, then scramble playing to show it was latched.
    task automatic run_frame(input logic [15:0] pl, output int lat);
        int m0;
        m0          = mix_cnt;
        playing     = pl;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        playing     = ~pl;
        wait_mix(m0, lat);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int d0;
        int r0;
        int m0;
        logic [POS_W-1:0] exp_pos[6];
        exp_pos[0] = 24'd1; exp_pos[1] = 24'd2; exp_pos[2] = 24'd3;
        exp_pos[3] = 24'd0; exp_pos[4] = 24'd1; exp_pos[5] = 24'd2;

        rst = 1'b1; sample_tick = 1'b0; playing = 16'h0; loop_len = 24'd100;
        pos_clr = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        rst    = 1'b0;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_rd_req", 64'(rd_req), 64'd0);
        chk("rst_position", 64'(position), 64'd0);
        chk("rst_flags", 64'({overrun, timeout_err, mix_data, data_ready}), 64'd0);

        // 1: no banks playing
        d0 = dr_cnt; r0 = req_cnt;
        run_frame(16'h0000, lat);
        chk("t1_latency", 64'(lat), 64'd49);
        chk("t1_dr_count", 64'(dr_cnt - d0), 64'd16);
        chk("t1_no_req", 64'(req_cnt - r0), 64'd0);
        chk("t1_word15", seen_word[15], 64'h0);
        chk("t1_position", 64'(position), 64'd1);

        // 2: banks 0 and 2 playing, ack +1, valid +3
        ack_lat = 1; val_lat = 3;
        d0 = dr_cnt; r0 = req_cnt; m0 = mix_cnt;
        run_frame(16'h0005, lat);
        chk("t2_latency", 64'(lat), 64'd61);
        chk("t2_req_cycles", 64'(req_cnt - r0), 64'd4);
        chk("t2_word_b0", seen_word[0], 64'hA5A5A5A5A0000001);
        chk("t2_word_b1", seen_word[1], 64'h0);
        chk("t2_word_b2", seen_word[2], 64'hA5A5A5A5A2000001);
        chk("t2_mix_once", 64'(mix_cnt - m0), 64'd1);
        chk("t2_position", 64'(position), 64'd2);

        // 3: clear in IDLE, loop_len=4, bank 2 playing, six frames
        pos_clr = 1'b1;
        @(negedge clk);
        pos_clr = 1'b0;
        chk("t3_pos_clr", 64'(position), 64'd0);
        loop_len = 24'd4; ack_lat = 0; val_lat = 0;
        for (int f = 0; f < 6; f++) begin
            run_frame(16'h0004, lat);
            chk("t3_position", 64'(position), 64'(exp_pos[f]));
            if (f == 3) chk("t3_word_b2_pos3", seen_word[2], 64'hA5A5A5A5A2000003);
        end
        chk("t3_latency", 64'(lat), 64'd51);

        // 4: bank 1 playing, data never returns
        loop_len = 24'd100; never_valid = 1'b1;
        run_frame(16'h0002, lat);
        never_valid = 1'b0;
        chk("t4_latency", 64'(lat), 64'd304);
        chk("t4_timeout_err", 64'(timeout_err), 64'd1);
        chk("t4_word_b1", seen_word[1], 64'h0);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t4_err_clr", 64'(timeout_err), 64'd0);
        chk("t4_position", 64'(position), 64'd3);

        // 5: second tick 10 cycles into the frame
        m0 = mix_cnt;
        playing = 16'h0000; sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        repeat (9) @(negedge clk);
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        @(negedge clk);
        chk("t5_overrun", 64'(overrun), 64'd1);
        wait_mix(m0, lat);
        chk("t5_latency", 64'(lat), 64'd49);
        repeat (60) @(negedge clk);
        chk("t5_mix_once", 64'(mix_cnt - m0), 64'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        chk("t5_err_clr", 64'(overrun), 64'd0);

        // 6: reset while waiting for data; the late rd_valid must be ignored
        chk("t6_pos_before", 64'(position), 64'd4);
        val_lat = 6;
        playing = 16'h0001; sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
        for (int i = 0; i < 20 && rd_req !== 1'b1; i++) @(negedge clk);
        for (int i = 0; i < 20 && rd_req === 1'b1; i++) @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_rd_req", 64'(rd_req), 64'd0);
        chk("t6_position", 64'(position), 64'd0);
        rst = 1'b0;
        d0 = dr_cnt;
        repeat (12) @(negedge clk);
        chk("t6_no_dr", 64'(dr_cnt - d0), 64'd0);
        chk("t6_dq_zero", mem_dq_o_b, 64'h0);
        val_lat = 0;

        // 7: wrap when already past loop_len-1, and loop_len==0
        run_frame(16'h0000, lat);
        run_frame(16'h0000, lat);
        chk("t7_pos2", 64'(position), 64'd2);
        loop_len = 24'd2;
        run_frame(16'h0000, lat);
        chk("t7_wrap_past", 64'(position), 64'd0);
        loop_len = 24'd100;
        run_frame(16'h0000, lat);
        loop_len = 24'd0;
        run_frame(16'h0000, lat);
        chk("t7_len_zero", 64'(position), 64'd0);

        repeat (5) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
